// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: single-transaction I2C register master (write or read) with open-drain SDA
module i2c_master_ctrl #(
   parameter int QTR          = 62,
   parameter bit CHK_DATA_ACK = 1'b0
) (
   input  logic       CLK,
   input  logic       Reset,
   input  logic       iStart,
   input  logic       iRW,
   input  logic [6:0] iDevID,
   input  logic [7:0] iRegAdd,
   input  logic [7:0] iWData,
   input  logic       iSDA,
   output logic       SCL,
   output logic       oSDA,
   output logic [7:0] oRData,
   output logic       oBusy,
   output logic       oDone,
   output logic       oNack
);
   localparam int QW = (QTR > 1) ? $clog2(QTR) : 1;

   typedef enum logic [3:0] {
      IDLE, START, ADDR, ACK1, REG, ACK2, WDATA, ACK3, RDATA, MNACK, STOP
   } stateT;

   stateT         state, stateNext;
   logic [QW-1:0] qCnt;
   logic [1:0]    phase;
   logic [2:0]    bitCnt;
   logic          rwQ;
   logic [6:0]    idQ;
   logic [7:0]    regQ, wdQ, shiftQ, addrByte;
   logic          qWrap, slotEnd, sampleNow, moved;

   assign addrByte  = {idQ, rwQ};
   assign qWrap     = qCnt == QW'(QTR - 1);
   assign slotEnd   = qWrap && phase == 2'd3;
   assign sampleNow = qWrap && phase == 2'd2;
   assign moved     = stateNext != state;
   assign oBusy     = state != IDLE;

   // state register
   always_ff @(posedge CLK)
      if (Reset) state <= IDLE;
      else       state <= stateNext;

   // next state and bus levels; SCL is low in Q0/Q1 and high in Q2/Q3 of every bit slot
   always_comb begin
      stateNext = state;
      SCL       = phase[1];
      oSDA      = 1'b1;
      case (state)
         IDLE: begin
            SCL = 1'b1;
            if (iStart) stateNext = START;
         end
         START: begin
            SCL  = 1'b1;
            oSDA = 1'b0;
            if (qWrap && phase == 2'd1) stateNext = ADDR;
         end
         ADDR: begin
            oSDA = addrByte[bitCnt];
            if (slotEnd && bitCnt == 3'd0) stateNext = ACK1;
         end
         ACK1:  if (slotEnd) stateNext = oNack ? STOP : REG;
         REG: begin
            oSDA = regQ[bitCnt];
            if (slotEnd && bitCnt == 3'd0) stateNext = ACK2;
         end
         ACK2:  if (slotEnd) stateNext = oNack ? STOP : rwQ ? RDATA : WDATA;
         WDATA: begin
            oSDA = wdQ[bitCnt];
            if (slotEnd && bitCnt == 3'd0) stateNext = ACK3;
         end
         ACK3:  if (slotEnd) stateNext = STOP;
         RDATA: if (slotEnd && bitCnt == 3'd0) stateNext = MNACK;
         MNACK: if (slotEnd) stateNext = STOP;
         STOP: begin
            oSDA = phase == 2'd3;
            if (slotEnd) stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   // quarter/phase/bit timing, request latching, ACK sampling and read shift register
   always_ff @(posedge CLK)
      if (Reset) begin
         qCnt   <= '0;
         phase  <= 2'd0;
         bitCnt <= 3'd0;
         rwQ    <= 1'b0;
         idQ    <= 7'd0;
         regQ   <= 8'd0;
         wdQ    <= 8'd0;
         shiftQ <= 8'd0;
         oRData <= 8'd0;
         oDone  <= 1'b0;
         oNack  <= 1'b0;
      end else begin
         qCnt   <= (state == IDLE || qWrap) ? '0 : qCnt + 1'b1;
         phase  <= (state == IDLE || moved) ? 2'd0 : qWrap ? phase + 2'd1 : phase;
         bitCnt <= moved ? 3'd7 : slotEnd ? bitCnt - 3'd1 : bitCnt;
         oDone  <= state == STOP && slotEnd;
         if (state == IDLE && iStart) begin
            rwQ   <= iRW;
            idQ   <= iDevID;
            regQ  <= iRegAdd;
            wdQ   <= iWData;
            oNack <= 1'b0;
         end
         if (sampleNow && iSDA && (state == ACK1 || state == ACK2 || (state == ACK3 && CHK_DATA_ACK)))
            oNack <= 1'b1;
         if (sampleNow && state == RDATA) shiftQ <= {shiftQ[6:0], iSDA};
         if (slotEnd && state == MNACK) oRData <= shiftQ;
      end
endmodule

// File: doc/i2c_master_ctrl.md
Name: i2c_master_ctrl

Overview:
- I2C bus master that generates SCL and drives SDA toward the register-slave on the board bus.
- Runs one transaction per request: a register write (START, {ID,W}, ACK, REG, ACK, DATA, ACK, STOP) or a register read (START, {ID,R}, ACK, REG, ACK, 8 data bits in, master NACK, STOP).
- Bus is open-drain: the top level forms iSDA as oSDA ANDed with the slave's SDA output. oSDA = 1 means the master releases the line.

Parameters:
- QTR, 62, quarter SCL period in CLK cycles. SCL half period = 2*QTR = 124 cycles, which matches the slave's half-cycle wait. Legal range ≥ 2.
- CHK_DATA_ACK, 0. When 1, a NACK on the write-data ACK slot sets oNack. When 0, that slot is sampled but ignored, because the slave does not ACK data.

Ports:
- CLK  input  1  system clock
- Reset  input  1  synchronous, active-high reset
- iStart  input  1  one-cycle request pulse; accepted only when oBusy=0
- iRW  input  1  1 = read, 0 = write
- iDevID  input  7  target device ID
- iRegAdd  input  8  register address byte
- iWData  input  8  write data byte
- iSDA  input  1  resolved SDA line level
- SCL  output  1  bus clock
- oSDA  output  1  master SDA drive (0 = pull low, 1 = release)
- oRData  output  8  last read byte; valid when oDone=1 after a read
- oBusy  output  1  transaction in progress
- oDone  output  1  one-cycle pulse at end of transaction
- oNack  output  1  error flag; valid with oDone, held until next accept

Behaviour:
Reset:
- All state is cleared synchronously on Reset=1: SCL=1, oSDA=1, oBusy=0, oDone=0, oNack=0, oRData=0, state IDLE, counters 0.
- Reset mid-transaction: lines are released on the next cycle and no STOP is generated.

Accept:
- iStart with oBusy=0 latches iRW, iDevID, iRegAdd and iWData.
- oBusy=1 from the next cycle; oNack is cleared.
- iStart while oBusy=1 is ignored, and the latched inputs are unchanged.

Timing:
- A quarter counter counts 0..QTR-1; each wrap advances the phase.
- Each bit slot has four quarters, Q0..Q3:
  - Q0, Q1: SCL=0. oSDA is updated at the start of Q0.
  - Q2, Q3: SCL=1. iSDA is sampled on the last cycle of Q2 (mid SCL-high).

States:
- IDLE: SCL=1, oSDA=1.
- START: oSDA=0 while SCL=1 for 2 quarters, then goes to ADDR.
- ADDR: 8 bits of {DevID[6:0], RW}, MSB first.
- ACK1: oSDA=1 and iSDA is sampled. iSDA=1 means NACK: set oNack and go to STOP. Otherwise go to REG.
- REG: 8 bits of RegAdd, MSB first.
- ACK2: same rule as ACK1. Then go to WDATA if RW=0, or RDATA if RW=1.
- WDATA: 8 bits of WData, MSB first.
- ACK3: sample iSDA. Set oNack only if CHK_DATA_ACK=1 and iSDA=1. Then go to STOP.
- RDATA: oSDA=1; 8 bits are shifted into a shift register MSB first.
- MNACK: oSDA=1 for one slot; oRData is loaded from the shift register. Then go to STOP.
- STOP, one 4-quarter slot:
  - Q0, Q1: SCL=0, oSDA=0.
  - Q2: SCL=1, oSDA=0.
  - Q3: SCL=1, oSDA=1.
  - Then oDone=1 for one cycle, oBusy=0 on the same cycle, and return to IDLE.

Latency, from the accept cycle to oDone:
- Full transaction: (2 + 27*4 + 4)*QTR = 114*QTR cycles, the same for read and write; 7068 cycles at the default.
- NACK at ACK1: (2 + 9*4 + 4)*QTR = 42*QTR.
- NACK at ACK2: 78*QTR.

Other rules:
- Bit counter is 3 bits and counts 7 down to 0. It is reloaded on entry to each byte state.
- oRData keeps its old value on write transactions and on NACK aborts.
- SDA never changes while SCL=1, except in the START and STOP quarters.

Test Plan:
- Write, QTR=62, iDevID=5, iRegAdd=0x3A, iWData=0x5C, slave model ACKs ID and REG -> SDA bytes 0x0A, 0x3A, 0x5C observed at SCL rising edges; oDone at cycle 7068; oNack=0; slave rRec=0x5C.
- Read, iDevID=5, iRegAdd=0x10, slave returns 0xF0 -> address byte 0x0B sent, MNACK slot SDA=1, oRData=0xF0 with oDone at cycle 7068, oNack=0.
- Wrong ID, iDevID=6, slave does not ACK -> STOP follows ACK1; oDone at 42*QTR=2604; oNack=1; oRData unchanged.
- CHK_DATA_ACK=1 write to a slave that does not ACK data -> oNack=1 at oDone. With CHK_DATA_ACK=0, the same stimulus gives oNack=0.
- iStart pulsed again at cycle 1000 with different iRegAdd=0x77 -> ignored; REG byte on the bus stays 0x3A.
- Reset asserted during REG bit 3 -> next cycle SCL=1, oSDA=1, oBusy=0, no oDone. A new iStart afterwards completes normally in 114*QTR cycles.
